// File: rtl/sequence_pattern_generator.sv
// rtl/sequence_pattern_generator.sv - MSB-first serial pattern transmitter with programmable repeat count.
// Optional one-cycle gap between repetitions when SEQGEN_GAP_EN is defined.
module sequence_pattern_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    output logic             x_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // shift_q holds the bits still to be sent; the bit on x lives in x_q.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        shift_d = shift_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pat_d   = pattern_i;
                    shift_d = pattern_i << 1;
                    rep_d   = repeat_i;
                    cnt_d   = '0;
                    x_d     = pattern_i[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    if (rep_q != '0) begin
                        rep_d = rep_q - CNT_W'(1);
`ifdef SEQGEN_GAP_EN
                        state_d = S_GAP;
`else
                        shift_d = pat_q << 1;
                        cnt_d   = '0;
                        x_d     = pat_q[WIDTH-1];
                        valid_d = 1'b1;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    x_d     = shift_q[WIDTH-1];
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + BW'(1);
                    valid_d = 1'b1;
                end
            end
`ifdef SEQGEN_GAP_EN
            S_GAP: begin
                busy_d  = 1'b1;
                shift_d = pat_q << 1;
                cnt_d   = '0;
                x_d     = pat_q[WIDTH-1];
                valid_d = 1'b1;
                state_d = S_SHIFT;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            shift_q <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shift_q <= shift_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_o     = x_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// tb/tb_sequence_pattern_generator.sv - directed self-checking bench for sequence_pattern_generator.
module tb_sequence_pattern_generator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] rep = 4'h0;
    logic       x, valid, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    sequence_pattern_generator #(.WIDTH(8), .CNT_W(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start_i  (start),
        .pattern_i(pattern),
        .repeat_i (rep),
        .x_o      (x),
        .valid_o  (valid),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clock = ~clock;

`ifdef SEQGEN_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a transfer at the current negedge and checks {valid,x,busy,done} every cycle
    // through the done pulse and the following idle cycle.
    task automatic xfer(input string tag, input logic [7:0] pat, input logic [3:0] r,
                        input int disturb_at, input bit hold_start);
        int n_tot;
        int off;
        int busy_cnt;
        int done_cnt;
        logic [3:0] exp;
        n_tot    = 8 * (int'(r) + 1) + (GAP ? int'(r) : 0);
        busy_cnt = 0;
        done_cnt = 0;
        pattern  = pat;
        rep      = r;
        start    = 1'b1;
        for (int c = 1; c <= n_tot + 2; c++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            if (c == disturb_at) begin
                start   = 1'b1;
                pattern = 8'hFF;
                rep     = 4'hF;
            end
            if (c == disturb_at + 1) start = 1'b0;
            if (c <= n_tot) begin
                off = GAP ? (c - 1) % 9 : (c - 1) % 8;
                exp = (off < 8) ? {1'b1, pat[7-off], 1'b1, 1'b0} : 4'b0010;
            end else if (c == n_tot + 1) begin
                exp = 4'b0011;
            end else begin
                exp = 4'b0000;
            end
            chk($sformatf("%s cyc%0d", tag, c), {28'd0, valid, x, busy, done}, {28'd0, exp});
            if (busy && !done) busy_cnt++;
            if (done) done_cnt++;
        end
        chk({tag, " busy_cycles"}, busy_cnt, n_tot);
        chk({tag, " done_count"}, done_cnt, 1);
    endtask

    initial begin
        // 1: reset and idle outputs
        repeat (2) @(negedge clock);
        chk("rst_low", {28'd0, valid, x, busy, done}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle", {28'd0, valid, x, busy, done}, 32'd0);
        #2 reset = 1'b0;
        #1 chk("async_idle", {28'd0, valid, x, busy, done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 2: single pattern
        xfer("t2", 8'b1011_0010, 4'd0, 0, 1'b0);
        // 3: three repetitions
        xfer("t3", 8'b1100_0001, 4'd2, 0, 1'b0);
        // 4: start and pattern disturbed mid-stream
        xfer("t4", 8'b0110_1001, 4'd0, 4, 1'b0);

        // 5: reset during a transfer
        pattern = 8'hC3;
        rep     = 4'd0;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t5 bit7", {28'd0, valid, x, busy, done}, 32'hE);
        @(negedge clock);
        chk("t5 bit6", {28'd0, valid, x, busy, done}, 32'hE);
        @(negedge clock);
        chk("t5 bit5", {28'd0, valid, x, busy, done}, 32'hA);
        #2 reset = 1'b0;
        #1 chk("t5 async_clear", {28'd0, valid, x, busy, done}, 32'd0);
        @(negedge clock);
        chk("t5 held", {28'd0, valid, x, busy, done}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("t5 released", {28'd0, valid, x, busy, done}, 32'd0);
        xfer("t5", 8'h5A, 4'd0, 0, 1'b0);

        // maximum repeat count
        xfer("max", 8'h81, 4'hF, 0, 1'b0);

        // 6: start held high, back-to-back transfers with one idle cycle between
        xfer("t6a", 8'hA5, 4'd0, 0, 1'b1);
        xfer("t6b", 8'h3C, 4'd0, 0, 1'b1);
        xfer("t6c", 8'hE1, 4'd0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
